// File: rtl/scarf_adc_pkg.sv
// Shared address map, per-channel offsets and CTRL bit positions for the
// multi-channel SCARF ADC register map.
package scarf_adc_pkg;

  localparam logic [7:0] ADDR_CTRL       = 8'h00;
  localparam logic [7:0] ADDR_CH_EN      = 8'h01;
  localparam logic [7:0] ADDR_THRESH_MSB = 8'h02;
  localparam logic [7:0] ADDR_THRESH_LSB = 8'h03;
  localparam logic [7:0] ADDR_STATUS     = 8'h04;
  localparam logic [7:0] ADDR_CH_BASE    = 8'h10;
  localparam int         CH_STRIDE       = 8;

  localparam int CTRL_ADC_EN   = 0;
  localparam int CTRL_REC_EN   = 1;
  localparam int CTRL_STAT_CLR = 2;

  typedef enum logic [2:0] {
    OFF_SMP_MSB = 3'd0,
    OFF_SMP_LSB = 3'd1,
    OFF_MAX_MSB = 3'd2,
    OFF_MAX_LSB = 3'd3,
    OFF_MIN_MSB = 3'd4,
    OFF_MIN_LSB = 3'd5,
    OFF_RSVD6   = 3'd6,
    OFF_RSVD7   = 3'd7
  } chOff_e;

  // Last byte address of the last channel block; the auto-increment stops here.
  function automatic logic [7:0] maxAddr(input int numCh);
    return 8'(int'(ADDR_CH_BASE) + CH_STRIDE * numCh - 1);
  endfunction

endpackage

// File: rtl/scarf_regmap_adc_multi_if.sv
// SCARF byte-bus between the deserialiser/serialiser (master) and a register map (slave).
interface scarf_regmap_adc_multi_if;

  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_finished;
  logic [6:0] slave_id;
  logic       rnw;
  logic [7:0] read_data_out;

  modport master (
    output data_in, data_in_valid, data_in_finished, slave_id, rnw,
    input  read_data_out
  );

  modport slave (
    input  data_in, data_in_valid, data_in_finished, slave_id, rnw,
    output read_data_out
  );

endinterface

// File: rtl/adc_chan_stats.sv
// One ADC channel: latest sample, running min/max and the over-threshold strobe.
module adc_chan_stats #(
  parameter int ADC_W = 12
) (
  input  logic             clk,
  input  logic             rst_n_sync,
  input  logic             capture_i,
  input  logic             statClr_i,
  input  logic [ADC_W-1:0] sample_i,
  input  logic [15:0]      thresh_i,
  output logic [15:0]      sample_o,
  output logic [15:0]      max_o,
  output logic [15:0]      min_o,
  output logic             overThresh_o
);

  logic [ADC_W-1:0] sample_q, sample_d;
  logic [ADC_W-1:0] max_q, max_d;
  logic [ADC_W-1:0] min_q, min_d;
  logic [15:0]      sampleExt;

  // A capture in the same cycle as a clear seeds both extremes with the new sample.
  always_comb begin
    sample_d = sample_q;
    max_d    = max_q;
    min_d    = min_q;
    if (statClr_i) begin
      max_d = '0;
      min_d = '1;
    end
    if (capture_i) begin
      sample_d = sample_i;
      if (statClr_i || (sample_i > max_q)) max_d = sample_i;
      if (statClr_i || (sample_i < min_q)) min_d = sample_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      sample_q <= '0;
      max_q    <= '0;
      min_q    <= '1;
    end else begin
      sample_q <= sample_d;
      max_q    <= max_d;
      min_q    <= min_d;
    end
  end

  always_comb begin
    sampleExt              = '0;
    sampleExt[ADC_W-1:0]   = sample_i;
    sample_o               = '0;
    sample_o[ADC_W-1:0]    = sample_q;
    max_o                  = '0;
    max_o[ADC_W-1:0]       = max_q;
    min_o                  = '0;
    min_o[ADC_W-1:0]       = min_q;
  end

  assign overThresh_o = capture_i && (sampleExt > thresh_i);

endmodule

// File: rtl/scarf_regmap_adc_multi.sv
// SCARF slave register map serving NUM_CH ADC channels with min/max tracking,
// sticky threshold flags and a shared shadow byte for coherent 16-bit reads.
module scarf_regmap_adc_multi
  import scarf_adc_pkg::*;
#(
  parameter logic [6:0] SLAVE_ID = 7'h02,
  parameter int         NUM_CH   = 4,
  parameter int         ADC_W    = 12
) (
  input  logic                    clk,
  input  logic                    rst_n_sync,
  scarf_regmap_adc_multi_if.slave bus,
  output logic                    cfg_adc_enable,
  output logic                    cfg_adc_record_en,
  output logic [NUM_CH-1:0]       cfg_ch_en,
  input  logic [NUM_CH*ADC_W-1:0] adc_data,
  input  logic [NUM_CH-1:0]       adc_data_valid
);

  localparam logic [7:0] MAX_ADDR = maxAddr(NUM_CH);

  logic [7:0]        addr_q, addr_d;
  logic              firstByte_q, firstByte_d;
  logic              finalByte_q, finalByte_d;
  logic [7:0]        shadow_q, shadow_d;
  logic              adcEnable_q, adcEnable_d;
  logic              recordEn_q, recordEn_d;
  logic [NUM_CH-1:0] chEn_q, chEn_d;
  logic [15:0]       thresh_q, thresh_d;
  logic [NUM_CH-1:0] status_q, status_d;

  logic              slaveHit, byteStb, dataByte, wrStb, rdStb, statClr;
  logic              inChRange;
  logic [2:0]        chIdx;
  chOff_e            chOff;
  logic [15:0]       selField;
  logic [7:0]        chanRead, regRead;
  logic [NUM_CH-1:0] w1cMask;
  logic [NUM_CH-1:0] chOver;
  logic [15:0]       chSample [NUM_CH];
  logic [15:0]       chMax    [NUM_CH];
  logic [15:0]       chMin    [NUM_CH];

  assign slaveHit  = (bus.slave_id == SLAVE_ID);
  assign byteStb   = bus.data_in_valid && slaveHit && !bus.data_in_finished;
  assign dataByte  = byteStb && !firstByte_q && !finalByte_q;
  assign wrStb     = dataByte && !bus.rnw;
  assign rdStb     = dataByte && bus.rnw;
  assign statClr   = wrStb && (addr_q == ADDR_CTRL) && bus.data_in[CTRL_STAT_CLR];

  // Base 0x10 with stride 8 puts the channel index in addr[5:3] offset by two.
  assign inChRange = (addr_q >= ADDR_CH_BASE) && (addr_q <= MAX_ADDR);
  assign chIdx     = addr_q[5:3] - 3'd2;
  assign chOff     = chOff_e'(addr_q[2:0]);

  for (genvar g = 0; g < NUM_CH; g++) begin : gChan
    adc_chan_stats #(.ADC_W(ADC_W)) uStats (
      .clk          (clk),
      .rst_n_sync   (rst_n_sync),
      .capture_i    (adc_data_valid[g] && adcEnable_q && chEn_q[g]),
      .statClr_i    (statClr),
      .sample_i     (adc_data[g*ADC_W +: ADC_W]),
      .thresh_i     (thresh_q),
      .sample_o     (chSample[g]),
      .max_o        (chMax[g]),
      .min_o        (chMin[g]),
      .overThresh_o (chOver[g])
    );
  end

  always_comb begin
    selField = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (chIdx == 3'(c)) begin
        case (chOff)
          OFF_SMP_MSB, OFF_SMP_LSB: selField = chSample[c];
          OFF_MAX_MSB, OFF_MAX_LSB: selField = chMax[c];
          OFF_MIN_MSB, OFF_MIN_LSB: selField = chMin[c];
          default:                  selField = '0;
        endcase
      end
    end
  end

  // LSB offsets always return the shadow so a 16-bit pair reads as one snapshot.
  always_comb begin
    chanRead = '0;
    case (chOff)
      OFF_SMP_MSB, OFF_MAX_MSB, OFF_MIN_MSB: chanRead = selField[15:8];
      OFF_SMP_LSB, OFF_MAX_LSB, OFF_MIN_LSB: chanRead = shadow_q;
      default:                               chanRead = '0;
    endcase
  end

  always_comb begin
    regRead = '0;
    if (inChRange) begin
      regRead = chanRead;
    end else begin
      case (addr_q)
        ADDR_CTRL: begin
          regRead[CTRL_ADC_EN] = adcEnable_q;
          regRead[CTRL_REC_EN] = recordEn_q;
        end
        ADDR_CH_EN:      regRead[NUM_CH-1:0] = chEn_q;
        ADDR_THRESH_MSB: regRead = thresh_q[15:8];
        ADDR_THRESH_LSB: regRead = thresh_q[7:0];
        ADDR_STATUS:     regRead[NUM_CH-1:0] = status_q;
        default:         regRead = '0;
      endcase
    end
  end

  always_comb begin
    bus.read_data_out = '0;
    if (slaveHit) begin
      if (firstByte_q && bus.rnw) bus.read_data_out = {1'b0, SLAVE_ID};
      else if (!finalByte_q)      bus.read_data_out = regRead;
    end
  end

  // Transaction end wins over any byte; the byte consumed at MAX_ADDR closes the burst.
  always_comb begin
    addr_d      = addr_q;
    firstByte_d = firstByte_q;
    finalByte_d = finalByte_q;
    shadow_d    = shadow_q;
    adcEnable_d = adcEnable_q;
    recordEn_d  = 1'b0;
    chEn_d      = chEn_q;
    thresh_d    = thresh_q;
    w1cMask     = '0;

    if (bus.data_in_finished) begin
      addr_d      = '0;
      firstByte_d = 1'b1;
      finalByte_d = 1'b0;
    end else if (byteStb) begin
      if (firstByte_q) begin
        addr_d      = bus.data_in;
        firstByte_d = 1'b0;
      end else if (!finalByte_q) begin
        if (addr_q == MAX_ADDR) finalByte_d = 1'b1;
        else                    addr_d      = addr_q + 8'd1;
      end
    end

    if (wrStb) begin
      case (addr_q)
        ADDR_CTRL: begin
          adcEnable_d = bus.data_in[CTRL_ADC_EN];
          recordEn_d  = bus.data_in[CTRL_REC_EN];
        end
        ADDR_CH_EN:      chEn_d         = bus.data_in[NUM_CH-1:0];
        ADDR_THRESH_MSB: thresh_d[15:8] = bus.data_in;
        ADDR_THRESH_LSB: thresh_d[7:0]  = bus.data_in;
        ADDR_STATUS:     w1cMask        = bus.data_in[NUM_CH-1:0];
        default: ;
      endcase
    end

    if (rdStb && inChRange) begin
      case (chOff)
        OFF_SMP_MSB, OFF_MAX_MSB, OFF_MIN_MSB: shadow_d = selField[7:0];
        default: ;
      endcase
    end

    status_d = (status_q & ~w1cMask) | chOver;
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      addr_q      <= '0;
      firstByte_q <= 1'b1;
      finalByte_q <= 1'b0;
      shadow_q    <= '0;
      adcEnable_q <= 1'b0;
      recordEn_q  <= 1'b0;
      chEn_q      <= '1;
      thresh_q    <= 16'hFFFF;
      status_q    <= '0;
    end else begin
      addr_q      <= addr_d;
      firstByte_q <= firstByte_d;
      finalByte_q <= finalByte_d;
      shadow_q    <= shadow_d;
      adcEnable_q <= adcEnable_d;
      recordEn_q  <= recordEn_d;
      chEn_q      <= chEn_d;
      thresh_q    <= thresh_d;
      status_q    <= status_d;
    end
  end

  assign cfg_adc_enable    = adcEnable_q;
  assign cfg_adc_record_en = recordEn_q;
  assign cfg_ch_en         = chEn_q;

endmodule

// File: tb/tb_scarf_regmap_adc_multi.sv
// Directed bench for scarf_regmap_adc_multi (SLAVE_ID=2, NUM_CH=4, ADC_W=12).
module tb_scarf_regmap_adc_multi;

  localparam int         NUM_CH = 4;
  localparam int         ADC_W  = 12;
  localparam logic [6:0] SID    = 7'h02;

  logic                    clk = 1'b0;
  logic                    rst_n_sync;
  logic                    cfg_adc_enable;
  logic                    cfg_adc_record_en;
  logic [NUM_CH-1:0]       cfg_ch_en;
  logic [NUM_CH*ADC_W-1:0] adc_data;
  logic [NUM_CH-1:0]       adc_data_valid;
  logic [7:0]              rd;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  scarf_regmap_adc_multi_if bus ();

  scarf_regmap_adc_multi #(
    .SLAVE_ID (SID),
    .NUM_CH   (NUM_CH),
    .ADC_W    (ADC_W)
  ) dut (
    .clk               (clk),
    .rst_n_sync        (rst_n_sync),
    .bus               (bus),
    .cfg_adc_enable    (cfg_adc_enable),
    .cfg_adc_record_en (cfg_adc_record_en),
    .cfg_ch_en         (cfg_ch_en),
    .adc_data          (adc_data),
    .adc_data_valid    (adc_data_valid)
  );

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; presents one byte for exactly one rising edge.
  task automatic applyStimulus(input logic [6:0] sid, input logic rw, input logic [7:0] b, output logic [7:0] rdOut);
    bus.slave_id      = sid;
    bus.rnw           = rw;
    bus.data_in       = b;
    bus.data_in_valid = 1'b1;
    #1 rdOut = bus.read_data_out;
    @(negedge clk);
    bus.data_in_valid = 1'b0;
  endtask

  task automatic rdByte(input string tag, input logic [7:0] b, input logic [7:0] expected);
    logic [7:0] r;
    applyStimulus(SID, 1'b1, b, r);
    checkOutput(tag, {8'h00, r}, {8'h00, expected});
  endtask

  task automatic wrByte(input logic [7:0] b);
    logic [7:0] r;
    applyStimulus(SID, 1'b0, b, r);
  endtask

  task automatic endTransaction();
    bus.data_in_finished = 1'b1;
    @(negedge clk);
    bus.data_in_finished = 1'b0;
  endtask

  task automatic injectSample(input int ch, input logic [ADC_W-1:0] v);
    adc_data[ch*ADC_W +: ADC_W] = v;
    adc_data_valid[ch]          = 1'b1;
    @(negedge clk);
    adc_data_valid = '0;
  endtask

  initial begin
    bus.data_in          = 8'h00;
    bus.data_in_valid    = 1'b0;
    bus.data_in_finished = 1'b0;
    bus.slave_id         = SID;
    bus.rnw              = 1'b0;
    adc_data             = '0;
    adc_data_valid       = '0;
    rst_n_sync           = 1'b0;
    repeat (3) @(negedge clk);
    rst_n_sync = 1'b1;
    @(negedge clk);

    checkOutput("rst_adc_en", {15'h0, cfg_adc_enable}, 16'h0);
    checkOutput("rst_rec_en", {15'h0, cfg_adc_record_en}, 16'h0);
    checkOutput("rst_ch_en", {12'h0, cfg_ch_en}, 16'h000F);
    checkOutput("rst_rdout", {8'h00, bus.read_data_out}, 16'h0000);

    rdByte("rd_id_ctrl", 8'h00, 8'h02);
    rdByte("ctrl_rst", 8'h00, 8'h00);
    endTransaction();
    rdByte("rd_id_thr", 8'h02, 8'h02);
    rdByte("thr_msb_rst", 8'h00, 8'hFF);
    rdByte("thr_lsb_rst", 8'h00, 8'hFF);
    rdByte("status_rst", 8'h00, 8'h00);
    endTransaction();

    applyStimulus(7'h05, 1'b0, 8'h00, rd);
    checkOutput("foreign_rd0", {8'h00, rd}, 16'h0000);
    applyStimulus(7'h05, 1'b0, 8'h03, rd);
    checkOutput("foreign_rd1", {8'h00, rd}, 16'h0000);
    endTransaction();
    checkOutput("foreign_no_wr", {15'h0, cfg_adc_enable}, 16'h0);

    wrByte(8'h00);
    wrByte(8'h03);
    checkOutput("ctrl_adc_en", {15'h0, cfg_adc_enable}, 16'h1);
    checkOutput("rec_pulse_hi", {15'h0, cfg_adc_record_en}, 16'h1);
    endTransaction();
    checkOutput("rec_pulse_lo", {15'h0, cfg_adc_record_en}, 16'h0);
    rdByte("rd_id_ctrl2", 8'h00, 8'h02);
    rdByte("ctrl_rb", 8'h00, 8'h01);
    endTransaction();

    injectSample(1, 12'h123);
    injectSample(1, 12'h0F0);
    injectSample(1, 12'h456);
    rdByte("rd_id_ch1", 8'h18, 8'h02);
    rdByte("ch1_smp_msb", 8'h00, 8'h04);
    rdByte("ch1_smp_lsb", 8'h00, 8'h56);
    rdByte("ch1_max_msb", 8'h00, 8'h04);
    rdByte("ch1_max_lsb", 8'h00, 8'h56);
    rdByte("ch1_min_msb", 8'h00, 8'h00);
    rdByte("ch1_min_lsb", 8'h00, 8'hF0);
    endTransaction();
    rdByte("rd_id_ch0", 8'h14, 8'h02);
    rdByte("ch0_min_msb", 8'h00, 8'h0F);
    rdByte("ch0_min_lsb", 8'h00, 8'hFF);
    endTransaction();

    wrByte(8'h02);
    wrByte(8'h04);
    wrByte(8'h00);
    endTransaction();
    injectSample(3, 12'h400);
    rdByte("rd_id_st0", 8'h04, 8'h02);
    rdByte("status_eq_thr", 8'h00, 8'h00);
    endTransaction();
    injectSample(2, 12'h401);
    rdByte("rd_id_st1", 8'h04, 8'h02);
    rdByte("status_set", 8'h00, 8'h04);
    endTransaction();

    wrByte(8'h04);
    adc_data[2*ADC_W +: ADC_W] = 12'h500;
    adc_data_valid[2]          = 1'b1;
    wrByte(8'h04);
    adc_data_valid = '0;
    endTransaction();
    rdByte("rd_id_st2", 8'h04, 8'h02);
    rdByte("status_set_wins", 8'h00, 8'h04);
    endTransaction();
    wrByte(8'h04);
    wrByte(8'h04);
    endTransaction();
    rdByte("rd_id_st3", 8'h04, 8'h02);
    rdByte("status_w1c", 8'h00, 8'h00);
    endTransaction();

    injectSample(1, 12'h1FF);
    rdByte("rd_id_coh", 8'h18, 8'h02);
    rdByte("coh_msb", 8'h00, 8'h01);
    injectSample(1, 12'h200);
    rdByte("coh_lsb", 8'h00, 8'hFF);
    endTransaction();
    rdByte("rd_id_coh2", 8'h18, 8'h02);
    rdByte("fresh_msb", 8'h00, 8'h02);
    rdByte("fresh_lsb", 8'h00, 8'h00);
    endTransaction();

    wrByte(8'h00);
    wrByte(8'h05);
    endTransaction();
    checkOutput("clr_keeps_en", {15'h0, cfg_adc_enable}, 16'h1);
    rdByte("rd_id_clr", 8'h1A, 8'h02);
    rdByte("clr_max_msb", 8'h00, 8'h00);
    rdByte("clr_max_lsb", 8'h00, 8'h00);
    rdByte("clr_min_msb", 8'h00, 8'h0F);
    rdByte("clr_min_lsb", 8'h00, 8'hFF);
    endTransaction();

    wrByte(8'h00);
    adc_data[0 +: ADC_W] = 12'h0AB;
    adc_data_valid[0]    = 1'b1;
    wrByte(8'h05);
    adc_data_valid = '0;
    endTransaction();
    rdByte("rd_id_clrs", 8'h12, 8'h02);
    rdByte("clrs_max_msb", 8'h00, 8'h00);
    rdByte("clrs_max_lsb", 8'h00, 8'hAB);
    rdByte("clrs_min_msb", 8'h00, 8'h00);
    rdByte("clrs_min_lsb", 8'h00, 8'hAB);
    endTransaction();

    wrByte(8'h2E);
    for (int i = 0; i < 4; i++) wrByte(8'hFE);
    endTransaction();
    checkOutput("burst_adc_en", {15'h0, cfg_adc_enable}, 16'h1);
    checkOutput("burst_ch_en", {12'h0, cfg_ch_en}, 16'h000F);

    wrByte(8'h02);
    wrByte(8'h12);
    endTransaction();
    wrByte(8'h01);
    wrByte(8'h03);
    endTransaction();
    checkOutput("reload_ch_en", {12'h0, cfg_ch_en}, 16'h0003);
    rdByte("rd_id_thr2", 8'h02, 8'h02);
    rdByte("thr2_msb", 8'h00, 8'h12);
    rdByte("thr2_lsb", 8'h00, 8'h00);
    endTransaction();

    injectSample(2, 12'h7AB);
    injectSample(1, 12'h333);
    rdByte("rd_id_gate", 8'h20, 8'h02);
    rdByte("gated_msb", 8'h00, 8'h05);
    rdByte("gated_lsb", 8'h00, 8'h00);
    endTransaction();
    rdByte("rd_id_open", 8'h18, 8'h02);
    rdByte("open_msb", 8'h00, 8'h03);
    rdByte("open_lsb", 8'h00, 8'h33);
    endTransaction();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/scarf_regmap_adc_multi.md
Name: scarf_regmap_adc_multi

Overview:
- Parametrised successor of the single-channel SCARF ADC register map.
- Serves NUM_CH ADC channels of ADC_W bits each behind one SCARF slave ID.
- Per channel: latest sample, running min/max, sticky over-threshold flags, and a coherent 16-bit read snapshot.
- Sits between the SCARF byte deserialiser and the ADC front-ends / block-RAM recorder.

Parameters:
SLAVE_ID, 7'h02, SCARF slave address this block answers to
NUM_CH, 4, number of ADC channels (1..8)
ADC_W, 12, sample width (1..16); zero-extended to 16 bits on read

Ports:
clk  input  1  system clock
rst_n_sync  input  1  asynchronous active-low reset (synchronised deassertion upstream)
data_in  input  8  SCARF byte from deserialiser
data_in_valid  input  1  one-cycle strobe, data_in valid
data_in_finished  input  1  one-cycle strobe, transaction end (chip-select released)
slave_id  input  7  slave ID of current transaction
rnw  input  1  1 = read transaction
read_data_out  output  8  byte to serialiser (combinational)
cfg_adc_enable  output  1  ADC enable, RW
cfg_adc_record_en  output  1  one-cycle record-start pulse
cfg_ch_en  output  NUM_CH  per-channel enable mask
adc_data  input  NUM_CH*ADC_W  packed samples, channel 0 in LSBs
adc_data_valid  input  NUM_CH  per-channel sample strobe

Behaviour:
- Protocol:
  - First byte of a valid-slave transaction loads the 8-bit address.
  - Each later byte auto-increments the address until MAX_ADDR (0x10+8*NUM_CH-1), where it holds.
  - The byte after the one at MAX_ADDR sets final_byte. From then on, reads return 0 and writes are ignored.
  - data_in_finished clears the address, first_byte (set to 1) and final_byte, and has priority over all else.
- read_data_out:
  - During the first byte of a read: {1'b0,SLAVE_ID}.
  - Otherwise: register at the current address.
  - Returns 0 for unmapped addresses, non-matching slave, or final_byte.
- Register map:
  - 0x00 CTRL:
    - [0] adc_enable, RW.
    - [1] record_en: write 1 gives a one-cycle pulse; reads current value.
    - [2] stat_clr: write 1 pulses a min/max reset; reads 0.
  - 0x01 CH_EN: [NUM_CH-1:0], RW.
  - 0x02/0x03 THRESH MSB/LSB: RW, 16-bit unsigned.
  - 0x04 STATUS: [NUM_CH-1:0] sticky over-threshold flags, W1C.
  - 0x10+8*ch (ch < NUM_CH), per-channel block:
    - +0 sample MSB.
    - +1 sample LSB, from the shadow register.
    - +2/+3 max MSB/LSB.
    - +4/+5 min MSB/LSB.
    - +6/+7 read 0.
- Coherency: on data_in_valid of a read byte at any per-channel MSB address (+0/+2/+4), the matching LSB is copied to a shared 8-bit shadow register. A following LSB read returns the shadow, never the live LSB.
- Sample path:
  - adc_data_valid[ch] captures the sample when cfg_adc_enable && cfg_ch_en[ch]. Otherwise the strobe is ignored.
  - max <= sample if sample > max; min <= sample if sample < min. Compare is on ADC_W bits, unsigned.
  - stat_clr pulse sets max to 0 and min to all-ones. A sample in the same cycle wins: max = min = sample.
  - sample > THRESH (sample zero-extended) sets STATUS[ch]. A set in the same cycle as a W1C clear wins.
- Reset values:
  - read-path registers 0; cfg_adc_enable 0; cfg_adc_record_en 0; cfg_ch_en all-ones.
  - THRESH 16'hFFFF; STATUS 0.
  - samples 0; max 0; min all-ones; shadow 0; address 0; first_byte 1; final_byte 0.
- Reset mid-transaction aborts immediately; no partial writes persist beyond those already completed.
- Writes take effect the cycle after data_in_valid. Register-write latency is one cycle; sample-update latency is one cycle.

Decomposition:
- Package scarf_adc_pkg holds:
  - address constants: ADDR_CTRL, ADDR_CH_EN, ADDR_THRESH_MSB/LSB, ADDR_STATUS, ADDR_CH_BASE, CH_STRIDE=8;
  - per-channel offset enum;
  - CTRL bit indices.
- Sub-module adc_chan_stats (sample/min/max/threshold compare for one channel), instantiated NUM_CH times in a generate loop.

Test Plan:
- Reset, then read addr 0x00 for 2 bytes with SLAVE_ID=2 -> bytes 0x02, 0x00; a write to slave 0x05 -> no register change, read_data_out 0.
- Write CTRL=0x03 -> cfg_adc_enable=1, cfg_adc_record_en high exactly 1 cycle; readback CTRL bit1=0.
- Ch1 samples 0x123, 0x0F0, 0x456 (ADC_W=12) -> per-channel registers read back:
  - sample = 0x04,0x56
  - max = 0x04,0x56
  - min = 0x00,0xF0
- THRESH=0x0400, ch2 sample 0x401 -> STATUS=0x04. Write STATUS=0x04 while another ch2 sample 0x500 arrives in the same cycle -> STATUS stays 0x04; next W1C -> 0x00.
- Burst-read 0x18,0x19 while ch1 changes 0x1FF->0x200 between bytes -> reads 0x01,0xFF (shadow coherent).
- Burst write from MAX_ADDR-1 for 4 bytes -> address stops at MAX_ADDR, extra bytes ignored. data_in_finished mid-burst, then a new transaction -> address reloads correctly.
